// File: rtl/pipe_decode.sv
// pipe_decode: Y86-64 decode/write-back stage.
// Holds the F->D pipeline register and the 15-entry register file. It produces
// the decode source/destination IDs and the forwarded operands for execute.
module pipe_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        f_instr_valid,
    input  logic        f_hlt,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstM,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] m_valM,
    input  logic [63:0] M_valE,
    input  logic [3:0]  W_dstM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valM,
    input  logic [63:0] W_valE,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [2:0]  D_stat,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [63:0] d_valA,
    output logic [63:0] d_valB
);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic [3:0] {
        I_HALT  = 4'h0,
        I_NOP   = 4'h1,
        I_CMOV  = 4'h2,
        I_IRMOV = 4'h3,
        I_RMMOV = 4'h4,
        I_MRMOV = 4'h5,
        I_OPQ   = 4'h6,
        I_JXX   = 4'h7,
        I_CALL  = 4'h8,
        I_RET   = 4'h9,
        I_PUSH  = 4'hA,
        I_POP   = 4'hB
    } icode_t;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    stat_t       stat_q;
    stat_t       stat_in;
    logic [63:0] regs [0:14];
    logic [63:0] rf_a;
    logic [63:0] rf_b;

    assign D_stat = stat_q;

    // Status of the instruction being loaded from fetch.
    always_comb begin
        stat_in = STAT_AOK;
        if (!f_instr_valid)
            stat_in = STAT_INS;
        else if (f_hlt && f_icode == I_HALT)
            stat_in = STAT_HLT;
    end

    // F->D pipeline register: reset/bubble load a nop, stall has priority over bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D_icode <= I_NOP;
            D_ifun  <= '0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= '0;
            D_valP  <= '0;
            stat_q  <= STAT_AOK;
        end else if (D_stall) begin
            D_icode <= D_icode;
        end else if (D_bubble) begin
            D_icode <= I_NOP;
            D_ifun  <= '0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= '0;
            D_valP  <= '0;
            stat_q  <= STAT_AOK;
        end else begin
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
            stat_q  <= stat_in;
        end
    end

    // Register file write; the M port is issued last so it wins on a shared ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 15; i++)
                regs[i] <= '0;
        end else begin
            if (W_dstE != RNONE)
                regs[W_dstE] <= W_valE;
            if (W_dstM != RNONE)
                regs[W_dstM] <= W_valM;
        end
    end

    // Source and destination register IDs per instruction class.
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            I_CMOV: begin
                d_srcA = D_rA;
                d_dstE = D_rB;
            end
            I_IRMOV: d_dstE = D_rB;
            I_RMMOV: begin
                d_srcA = D_rA;
                d_srcB = D_rB;
            end
            I_MRMOV: begin
                d_srcB = D_rB;
                d_dstM = D_rA;
            end
            I_OPQ: begin
                d_srcA = D_rA;
                d_srcB = D_rB;
                d_dstE = D_rB;
            end
            I_CALL: begin
                d_srcB = RRSP;
                d_dstE = RRSP;
            end
            I_RET: begin
                d_srcA = RRSP;
                d_srcB = RRSP;
                d_dstE = RRSP;
            end
            I_PUSH: begin
                d_srcA = D_rA;
                d_srcB = RRSP;
                d_dstE = RRSP;
            end
            I_POP: begin
                d_srcA = RRSP;
                d_srcB = RRSP;
                d_dstE = RRSP;
                d_dstM = D_rA;
            end
            default: ;
        endcase
    end

    // Combinational register-file reads; ID F reads as zero.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        if (d_srcA != RNONE)
            rf_a = regs[d_srcA];
        if (d_srcB != RNONE)
            rf_b = regs[d_srcB];
    end

    // Forwarding in pipeline-age order: newest producer first, register file last.
    function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rf);
        if (src == RNONE)       return '0;
        else if (src == e_dstE) return e_valE;
        else if (src == M_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return rf;
    endfunction

    // Operand select; jXX and call carry valP on the A path.
    always_comb begin
        d_valA = fwd(d_srcA, rf_a);
        d_valB = fwd(d_srcB, rf_b);
        if (D_icode == I_JXX || D_icode == I_CALL)
            d_valA = D_valP;
    end

endmodule

// File: tb/tb_pipe_decode.sv
// Testbench for pipe_decode: directed vectors, expected values queued by the
// stimulus and compared by an independent monitor at each sample point.
module tb_pipe_decode;

    logic        clk, rst, D_stall, D_bubble;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic        f_instr_valid, f_hlt;
    logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
    logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [2:0]  D_stat;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB;

    pipe_decode dut (
        .clk(clk), .rst(rst), .D_stall(D_stall), .D_bubble(D_bubble),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_instr_valid(f_instr_valid), .f_hlt(f_hlt),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstM(M_dstM), .M_dstE(M_dstE),
        .m_valM(m_valM), .M_valE(M_valE), .W_dstM(W_dstM), .W_dstE(W_dstE),
        .W_valM(W_valM), .W_valE(W_valE),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB)
    );

    localparam int S_ICODE = 0, S_IFUN = 1, S_RA = 2, S_RB = 3, S_VALC = 4, S_VALP = 5,
                   S_STAT = 6, S_SRCA = 7, S_SRCB = 8, S_DSTE = 9, S_DSTM = 10,
                   S_VALA = 11, S_VALB = 12;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   sample_tog = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pick(input int sel);
        case (sel)
            S_ICODE: return 64'(D_icode);
            S_IFUN:  return 64'(D_ifun);
            S_RA:    return 64'(D_rA);
            S_RB:    return 64'(D_rB);
            S_VALC:  return D_valC;
            S_VALP:  return D_valP;
            S_STAT:  return 64'(D_stat);
            S_SRCA:  return 64'(d_srcA);
            S_SRCB:  return 64'(d_srcB);
            S_DSTE:  return 64'(d_dstE);
            S_DSTM:  return 64'(d_dstM);
            S_VALA:  return d_valA;
            default: return d_valB;
        endcase
    endfunction

    // Monitor: drains the scoreboard whenever the stimulus marks a sample point.
    initial begin
        exp_t e;
        logic [63:0] act;
        forever begin
            @(sample_tog);
            while (q.size() > 0) begin
                e = q.pop_front();
                act = pick(e.sel);
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [63:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic sample();
        sample_tog = ~sample_tog;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_f(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] valp);
        f_icode = ic;
        f_ifun  = 4'h0;
        f_rA    = ra;
        f_rB    = rb;
        f_valP  = valp;
    endtask

    initial begin
        rst = 1; D_stall = 0; D_bubble = 0;
        set_f(4'h1, 4'hF, 4'hF, 64'h0);
        f_valC = 64'h0; f_instr_valid = 1; f_hlt = 0;
        e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
        e_valE = '0; m_valM = '0; M_valE = '0; W_valM = '0; W_valE = '0;

        // Reset state
        #12;
        expect_val("rst_icode", S_ICODE, 64'h1);
        expect_val("rst_ifun",  S_IFUN,  64'h0);
        expect_val("rst_rA",    S_RA,    64'hF);
        expect_val("rst_rB",    S_RB,    64'hF);
        expect_val("rst_valP",  S_VALP,  64'h0);
        expect_val("rst_stat",  S_STAT,  64'h1);
        expect_val("rst_srcA",  S_SRCA,  64'hF);
        expect_val("rst_valA",  S_VALA,  64'h0);
        expect_val("rst_valB",  S_VALB,  64'h0);
        sample();

        // Preload reg2=5, reg3=7 through the W ports
        @(negedge clk);
        rst = 0;
        W_dstE = 4'h2; W_valE = 64'h5;
        W_dstM = 4'h3; W_valM = 64'h7;
        step();
        W_dstE = 4'hF; W_dstM = 4'hF;
        set_f(4'h6, 4'h2, 4'h3, 64'h12);
        f_valC = 64'h1234;
        step();
        expect_val("opq_icode", S_ICODE, 64'h6);
        expect_val("opq_valC",  S_VALC,  64'h1234);
        expect_val("opq_valP",  S_VALP,  64'h12);
        expect_val("opq_srcA",  S_SRCA,  64'h2);
        expect_val("opq_srcB",  S_SRCB,  64'h3);
        expect_val("opq_dstE",  S_DSTE,  64'h3);
        expect_val("opq_dstM",  S_DSTM,  64'hF);
        expect_val("opq_valA",  S_VALA,  64'h5);
        expect_val("opq_valB",  S_VALB,  64'h7);
        sample();

        // Forwarding priority, all within one cycle
        e_dstE = 4'h2; e_valE = 64'hAA;
        M_dstE = 4'h2; M_valE = 64'hBB;
        W_dstE = 4'h2; W_valE = 64'hCC;
        #1; expect_val("fwd_e", S_VALA, 64'hAA); sample();
        e_dstE = 4'hF;
        #1; expect_val("fwd_M", S_VALA, 64'hBB); sample();
        M_dstE = 4'hF;
        W_dstM = 4'h2; W_valM = 64'h11;
        #1; expect_val("fwd_WM_over_WE", S_VALA, 64'h11); sample();
        W_dstM = 4'hF;
        #1; expect_val("fwd_W", S_VALA, 64'hCC); sample();
        W_dstE = 4'hF;
        M_dstM = 4'h3; m_valM = 64'hDD;
        M_dstE = 4'h3; M_valE = 64'hEE;
        #1; expect_val("fwd_Mm_over_ME", S_VALB, 64'hDD); sample();
        M_dstM = 4'hF; M_dstE = 4'hF;

        // Call, then stall (also with bubble), then bubble
        set_f(4'h8, 4'hF, 4'hF, 64'h40);
        step();
        expect_val("call_icode", S_ICODE, 64'h8);
        expect_val("call_valA",  S_VALA,  64'h40);
        expect_val("call_srcB",  S_SRCB,  64'h4);
        expect_val("call_dstE",  S_DSTE,  64'h4);
        expect_val("call_valB",  S_VALB,  64'h0);
        sample();
        D_stall = 1;
        set_f(4'h6, 4'h1, 4'h1, 64'h99);
        step();
        expect_val("stall1_icode", S_ICODE, 64'h8);
        expect_val("stall1_valA",  S_VALA,  64'h40);
        sample();
        D_bubble = 1;
        f_valP = 64'h77;
        step();
        expect_val("stall2_icode", S_ICODE, 64'h8);
        expect_val("stall2_valA",  S_VALA,  64'h40);
        sample();
        D_stall = 0;
        step();
        expect_val("bub_icode", S_ICODE, 64'h1);
        expect_val("bub_rA",    S_RA,    64'hF);
        expect_val("bub_valP",  S_VALP,  64'h0);
        expect_val("bub_valA",  S_VALA,  64'h0);
        sample();
        D_bubble = 0;

        // Write-back collision on reg4, then popq reads it
        W_dstE = 4'h4; W_valE = 64'h100;
        W_dstM = 4'h4; W_valM = 64'h200;
        set_f(4'hB, 4'h5, 4'hF, 64'h0);
        step();
        W_dstE = 4'hF; W_dstM = 4'hF;
        #1;
        expect_val("pop_valA", S_VALA, 64'h200);
        expect_val("pop_valB", S_VALB, 64'h200);
        expect_val("pop_dstE", S_DSTE, 64'h4);
        expect_val("pop_dstM", S_DSTM, 64'h5);
        sample();

        // Status
        f_instr_valid = 0;
        set_f(4'hD, 4'h1, 4'h2, 64'h0);
        step();
        expect_val("ins_stat", S_STAT, 64'h4);
        expect_val("ins_srcA", S_SRCA, 64'hF);
        expect_val("ins_srcB", S_SRCB, 64'hF);
        expect_val("ins_dstE", S_DSTE, 64'hF);
        expect_val("ins_dstM", S_DSTM, 64'hF);
        sample();
        f_instr_valid = 1; f_hlt = 1;
        set_f(4'h0, 4'hF, 4'hF, 64'h0);
        step();
        expect_val("hlt_stat",  S_STAT,  64'h2);
        expect_val("hlt_icode", S_ICODE, 64'h0);
        sample();
        set_f(4'h1, 4'hF, 4'hF, 64'h0);
        step();
        expect_val("nop_hlt_stat", S_STAT, 64'h1);
        sample();
        f_hlt = 0;

        // Asynchronous reset mid-cycle with D loaded
        set_f(4'h6, 4'h2, 4'h3, 64'h0);
        step();
        expect_val("pre_rst_valA", S_VALA, 64'h5);
        sample();
        #2;
        rst = 1;
        #1;
        expect_val("arst_icode", S_ICODE, 64'h1);
        expect_val("arst_stat",  S_STAT,  64'h1);
        expect_val("arst_srcA",  S_SRCA,  64'hF);
        expect_val("arst_valA",  S_VALA,  64'h0);
        sample();
        @(negedge clk);
        rst = 0;
        for (int r = 0; r < 15; r++) begin
            set_f(4'h4, 4'(r), 4'(14 - r), 64'h0);
            step();
            expect_val($sformatf("clr_reg%0d", r), S_VALA, 64'h0);
            expect_val($sformatf("clr_reg%0d", 14 - r), S_VALB, 64'h0);
            sample();
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) #1;
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending expected 0 pending", q.size());
            failures += q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_decode.md
# pipe_decode

Decode/write-back stage of the Y86-64 pipeline. It holds the F→D pipeline register (D_*) that captures the fetch-stage outputs (f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_instr_valid, f_hlt). It contains the 15-entry 64-bit register file, written from the W stage. It produces the decode-stage source and destination IDs and the forwarded operands d_valA/d_valB for the execute stage.

## Interface
- No parameters. Register IDs are 4-bit; 4'hF = RNONE; %rsp = 4.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- D_stall  in  1  hold D register contents
- D_bubble  in  1  load a nop bubble into D register
- f_icode, f_ifun, f_rA, f_rB  in  4 each  fetch outputs
- f_valC, f_valP  in  64 each  fetch outputs
- f_instr_valid, f_hlt  in  1 each  fetch status
- e_dstE  in  4;  e_valE  in  64  execute-stage forward source
- M_dstM, M_dstE  in  4;  m_valM, M_valE  in  64  memory-stage forward sources
- W_dstM, W_dstE  in  4;  W_valM, W_valE  in  64  write-back ports and forward sources
- D_icode, D_ifun, D_rA, D_rB  out  4  registered decode fields
- D_valC, D_valP  out  64  registered
- D_stat  out  3  registered status: 1 AOK, 2 HLT, 3 ADR (unused here), 4 INS
- d_srcA, d_srcB, d_dstE, d_dstM  out  4  combinational IDs
- d_valA, d_valB  out  64  combinational forwarded operands

## Operation
- D register update on rising edge, priority:
  - rst: loads the bubble value (async).
  - D_stall: holds.
  - D_bubble: loads the bubble value.
  - Otherwise loads f_*.
- Bubble value: icode 1, ifun 0, rA = rB = F, valC = valP = 0, stat AOK.
- Stall and bubble asserted together: stall wins.
- Loaded stat:
  - INS if !f_instr_valid.
  - Else HLT if f_hlt && f_icode == 0.
  - Else AOK.
- Icodes: 0 halt, 1 nop, 2 cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 OPq, 7 jXX, 8 call, 9 ret, A push, B pop. Any other icode decodes all IDs to F.
- d_srcA: rA for 2, 4, 6, A; 4 for 9, B; else F.
- d_srcB: rB for 4, 5, 6; 4 for 8, 9, A, B; else F.
- d_dstE: rB for 2, 3, 6; 4 for 8, 9, A, B; else F. cmov dstE is unconditional; execute squashes it on !Cnd.
- d_dstM: rA for 5, B; else F.
- d_valA:
  - D_valP if D_icode is 7 or 8.
  - Else the first matching source of d_srcA, in priority order: e_dstE→e_valE, M_dstM→m_valM, M_dstE→M_valE, W_dstM→W_valM, W_dstE→W_valE.
  - Else the register-file value.
- d_valB: same forwarding priority on d_srcB, with no valP select.
- A source ID of F never matches a forward source and yields 0.
- Register file: registers 0–14, all cleared to 0 by rst.
  - On rising edge, W_dstE≠F writes W_valE and W_dstM≠F writes W_valM.
  - If W_dstE == W_dstM ≠ F, W_valM is written.
  - Writes to ID F are ignored.
  - Reads are combinational on d_srcA/d_srcB.

## Timing
- Reset values: D_icode 1, D_ifun 0, D_rA F, D_rB F, D_valC 0, D_valP 0, D_stat 1. The d_* outputs follow combinationally: IDs F, d_valA 0, d_valB 0.
- Reset mid-operation clears the D register and all 15 registers immediately, without waiting for a clock edge.
- Latency: f_* to D_* takes 1 cycle. D_* to d_* is combinational, with zero cycles.
- Register-file write data is visible on the read port after the edge. During the same cycle, W forwarding supplies the value, so there is no read-after-write hazard.
- Load/use hazards (a source matches E_dstM) are not handled here. The pipeline controller asserts D_stall.

## Test plan
- Reset: assert rst mid-cycle with D loaded → D_icode 1, D_stat 1, d_srcA F, and every register reads 0 immediately.
- Load: f = OPq (6,0), rA 2, rB 3, valP 0x12, reg2 = 5, reg3 = 7, no forwards → next cycle d_srcA 2, d_srcB 3, d_dstE 3, d_valA 5, d_valB 7.
- Forward priority: d_srcA = 2; e_dstE = 2 (0xAA), M_dstE = 2 (0xBB), W_dstE = 2 (0xCC) → d_valA 0xAA. Drop e_dstE → 0xBB. Drop M_dstE → 0xCC.
- Control: D loaded with call (8), f_valP 0x40, then hold D_stall for 2 cycles while f changes → D_icode stays 8 and d_valA = 0x40. Then D_stall = 0 with D_bubble = 1 → D_icode 1, D_rA F.
- Write-back: W_dstE = 4 (0x100) and W_dstM = 4 (0x200) on the same edge → reg4 = 0x200. A later popq in D reads d_valA = 0x200 from the register file.
- Status: f_instr_valid = 0, f_icode 0xD → D_stat 4, all d_* IDs F. f_icode 0 with f_hlt 1 → D_stat 2.
